juri_vote_tx: RTL and testbench

- Juror-side console transmitter. It turns raw button presses into the 2-bit jury code J[1:0] consumed by the jury input stage.
- Per voting round it debounces the buttons, locks the first valid choice, and presents the code with a valid/ack handshake.
- It holds the code stable until the voting round closes.
- One instance exists per juror, between the pushbuttons and the jury input circuit.

---
 rtl/juri_vote_tx.sv | 161 ++++++++++++++++
 tb/tb_juri_vote_tx.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/juri_vote_tx.sv
// rtl/juri_vote_tx.sv - juror console vote transmitter; optional auto-abstain via JURI_VOTE_TIMEOUT_EN
module juri_vote_tx #(
   parameter int DEB_CYCLES     = 16,
   parameter int DEB_W          = 5,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int TO_W           = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       round_open,
   input  logic       round_close,
   input  logic       btn_yes,
   input  logic       btn_no,
   input  logic       btn_abs,
   input  logic       ack,
   output logic [1:0] J,
   output logic       valid,
   output logic       locked
);

   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, SEND = 2'd2, HOLD = 2'd3} state_t;

   state_t           state, state_n;
   logic [2:0]       sync1, sync2;
   logic [1:0]       cand, cand_q;
   logic [DEB_W-1:0] deb_cnt;
   logic             deb_same, deb_done, timeout_hit;
   logic [1:0]       j_n;
   logic             valid_n, locked_n;

   // two-flop synchronisers for the raw buttons, packed as {abs, no, yes}
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 3'b000;
         sync2 <= 3'b000;
      end else begin
         sync1 <= {btn_abs, btn_no, btn_yes};
         sync2 <= sync1;
      end
   end

   // one-hot decode: only a single pressed button yields a candidate code
   always_comb begin
      cand = 2'b00;
      case (sync2)
         3'b001:  cand = 2'b01;
         3'b010:  cand = 2'b10;
         3'b100:  cand = 2'b11;
         default: cand = 2'b00;
      endcase
   end

   assign deb_same = (cand != 2'b00) && (cand == cand_q);
   assign deb_done = deb_same && (deb_cnt == DEB_W'(DEB_CYCLES - 2));

   // debounce run counter; cand_q reads 0 outside ARMED so a button already held at round open starts a fresh run
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cand_q  <= 2'b00;
         deb_cnt <= '0;
      end else begin
         cand_q  <= (state == ARMED) ? cand : 2'b00;
         deb_cnt <= (state == ARMED && deb_same) ? deb_cnt + DEB_W'(1) : '0;
      end
   end

`ifdef JURI_VOTE_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt;

   // timeout counter: held at 0 outside ARMED, counts every cycle spent in ARMED
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         to_cnt <= '0;
      else if (state == ARMED)
         to_cnt <= to_cnt + TO_W'(1);
      else
         to_cnt <= '0;
   end

   assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 2));
`else
   // no automatic abstain in this build; ARMED waits for a button or round_close
   assign timeout_hit = (TIMEOUT_CYCLES < 0) && (TO_W < 0);
`endif

   // state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         J      <= 2'b00;
         valid  <= 1'b0;
         locked <= 1'b0;
      end else begin
         state  <= state_n;
         J      <= j_n;
         valid  <= valid_n;
         locked <= locked_n;
      end
   end

   // next state and next outputs; round_close outranks every other event
   always_comb begin
      state_n  = state;
      j_n      = J;
      valid_n  = valid;
      locked_n = locked;
      case (state)
         IDLE: begin
            j_n      = 2'b00;
            valid_n  = 1'b0;
            locked_n = 1'b0;
            if (round_open && !round_close)
               state_n = ARMED;
         end
         ARMED: begin
            if (round_close) begin
               state_n  = IDLE;
               j_n      = 2'b00;
               valid_n  = 1'b0;
               locked_n = 1'b0;
            end else if (deb_done) begin
               state_n  = SEND;
               j_n      = cand;
               valid_n  = 1'b1;
               locked_n = 1'b1;
            end else if (timeout_hit) begin
               state_n  = SEND;
               j_n      = 2'b11;
               valid_n  = 1'b1;
               locked_n = 1'b1;
            end
         end
         SEND: begin
            if (round_close) begin
               state_n  = IDLE;
               j_n      = 2'b00;
               valid_n  = 1'b0;
               locked_n = 1'b0;
            end else if (ack) begin
               state_n  = HOLD;
               valid_n  = 1'b0;
            end
         end
         HOLD: begin
            if (round_close) begin
               state_n  = IDLE;
               j_n      = 2'b00;
               valid_n  = 1'b0;
               locked_n = 1'b0;
            end
         end
         default: begin
            state_n  = IDLE;
            j_n      = 2'b00;
            valid_n  = 1'b0;
            locked_n = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_juri_vote_tx.sv
// tb/tb_juri_vote_tx.sv - randomized self-checking bench for juri_vote_tx against a behavioural vote model
module tb_juri_vote_tx;

   localparam int DEB = 16;
   localparam int TMO = 1000;

   logic       clk;
   logic       rst_n;
   logic       round_open, round_close, btn_yes, btn_no, btn_abs, ack;
   logic [1:0] J;
   logic       valid, locked;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model: round phase 0 idle, 1 armed, 2 sent, 3 held
   int         m_phase, m_j, m_valid, m_locked, m_arm;
   logic [2:0] bq[$];
   int         ch[$];

   juri_vote_tx dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .round_open  (round_open),
      .round_close (round_close),
      .btn_yes     (btn_yes),
      .btn_no      (btn_no),
      .btn_abs     (btn_abs),
      .ack         (ack),
      .J           (J),
      .valid       (valid),
      .locked      (locked)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   function automatic int decode(input logic [2:0] b);
      if ($countones(b) != 1) return 0;
      if (b[0]) return 1;
      if (b[1]) return 2;
      return 3;
   endfunction

   task automatic model_reset();
      m_phase  = 0;
      m_j      = 0;
      m_valid  = 0;
      m_locked = 0;
      m_arm    = 0;
      bq       = '{3'b000, 3'b000};
      ch.delete();
   endtask

   task automatic model_close();
      m_phase  = 0;
      m_j      = 0;
      m_valid  = 0;
      m_locked = 0;
   endtask

   task automatic model_lock(input int code);
      m_phase  = 2;
      m_j      = code;
      m_valid  = 1;
      m_locked = 1;
   endtask

   // one clock edge of the model: buttons are seen two edges late; a vote needs DEB equal samples all inside the round
   task automatic model_edge();
      logic [2:0] b;
      int         c, cyc;
      bit         stable;
      b = bq.pop_front();
      bq.push_back({btn_abs, btn_no, btn_yes});
      c = decode(b);
      ch.push_back(c);
      cyc = ch.size() - 1;
      case (m_phase)
         0: if (round_open && !round_close) begin
               m_phase = 1;
               m_arm   = cyc;
            end
         1: begin
               stable = (c != 0) && (cyc - m_arm >= DEB);
               if (stable)
                  for (int k = 1; k < DEB; k++)
                     if (ch[cyc-k] != c) stable = 0;
               if (round_close)
                  model_close();
               else if (stable)
                  model_lock(c);
`ifdef JURI_VOTE_TIMEOUT_EN
               else if (cyc - m_arm == TMO - 1)
                  model_lock(3);
`endif
            end
         2: if (round_close)
               model_close();
            else if (ack) begin
               m_phase = 3;
               m_valid = 0;
            end
         default: if (round_close) model_close();
      endcase
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
      check("J", J, m_j);
      check("valid", valid, m_valid);
      check("locked", locked, m_locked);
   endtask

   task automatic pulse_open();
      round_open = 1'b1;
      tick();
      round_open = 1'b0;
   endtask

   task automatic pulse_close();
      round_close = 1'b1;
      tick();
      round_close = 1'b0;
   endtask

   task automatic pulse_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   initial begin
      int lat;
      int r;
      rst_n = 1'b0;
      round_open = 1'b0; round_close = 1'b0; ack = 1'b0;
      btn_yes = 1'b0; btn_no = 1'b0; btn_abs = 1'b0;
      model_reset();

      // reset, then a press without an open round
      repeat (3) tick();
      check("reset_j", J, 0);
      rst_n = 1'b1;
      btn_yes = 1'b1;
      repeat (20) tick();
      check("idle_ignore_locked", locked, 0);
      btn_yes = 1'b0;
      repeat (3) tick();

      // yes vote with latency measurement
      pulse_open();
      btn_yes = 1'b1;
      lat = 0;
      for (int i = 1; i <= 30; i++) begin
         tick();
         if (valid && lat == 0) lat = i;
      end
      check("yes_latency", lat, 2 + DEB);
      check("yes_code", J, 1);
      btn_yes = 1'b0;
      pulse_ack();
      check("ack_drop", valid, 0);
      check("hold_j", J, 1);
      repeat (5) tick();
      pulse_close();
      check("close_j", J, 0);

      // bouncing button, then two buttons together, then abstain alone
      pulse_open();
      for (int i = 0; i < 40; i++) begin
         if (i % 5 == 0) btn_no = ~btn_no;
         tick();
      end
      btn_no = 1'b1; btn_abs = 1'b1;
      repeat (40) tick();
      check("conflict_nolock", locked, 0);
      btn_no = 1'b0;
      repeat (2 + DEB) tick();
      check("abs_code", J, 3);
      check("abs_valid", valid, 1);
      btn_abs = 1'b0;
      pulse_ack();
      pulse_close();

      // attempt to change a locked vote
      pulse_open();
      btn_no = 1'b1;
      repeat (2 + DEB) tick();
      check("no_code", J, 2);
      btn_no = 1'b0;
      pulse_ack();
      btn_yes = 1'b1;
      repeat (50) tick();
      check("nochange_j", J, 2);
      check("nochange_locked", locked, 1);
      btn_yes = 1'b0;
      pulse_close();

      // close and ack together while sending
      pulse_open();
      btn_yes = 1'b1;
      repeat (2 + DEB) tick();
      btn_yes = 1'b0;
      check("pre_valid", valid, 1);
      round_close = 1'b1; ack = 1'b1;
      tick();
      round_close = 1'b0; ack = 1'b0;
      check("prio_j", J, 0);
      check("prio_valid", valid, 0);
      check("prio_locked", locked, 0);

      // asynchronous reset while holding a vote
      pulse_open();
      btn_abs = 1'b1;
      repeat (2 + DEB) tick();
      btn_abs = 1'b0;
      pulse_ack();
      check("hold_locked", locked, 1);
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("arst_hold_j", J, 0);
      check("arst_hold_locked", locked, 0);
      tick();
      rst_n = 1'b1;

      // asynchronous reset mid-armed; the pending press must not survive it
      pulse_open();
      btn_yes = 1'b1;
      repeat (8) tick();
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("arst_armed_valid", valid, 0);
      tick();
      rst_n = 1'b1;
      repeat (25) tick();
      check("arst_no_vote", locked, 0);
      btn_yes = 1'b0;

      // idle round with no buttons
      pulse_open();
      repeat (2000) tick();
`ifdef JURI_VOTE_TIMEOUT_EN
      check("timeout_abstain", J, 3);
`else
      check("no_timeout_j", J, 0);
`endif
      pulse_close();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         round_open  = ($urandom_range(99) < 3);
         round_close = ($urandom_range(199) < 2);
         ack         = ($urandom_range(9) == 0);
         if ($urandom_range(19) == 0) begin
            r = $urandom_range(5);
            case (r)
               0: {btn_abs, btn_no, btn_yes} = 3'b001;
               1: {btn_abs, btn_no, btn_yes} = 3'b010;
               2: {btn_abs, btn_no, btn_yes} = 3'b100;
               3: {btn_abs, btn_no, btn_yes} = 3'b000;
               default: {btn_abs, btn_no, btn_yes} = 3'($urandom_range(7));
            endcase
         end
         tick();
      end
      round_open = 1'b0; round_close = 1'b0; ack = 1'b0;
      btn_yes = 1'b0; btn_no = 1'b0; btn_abs = 1'b0;
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
